// File: rtl/cordic_pkg.sv
// Shared encodings for the iterative CORDIC engine: coordinate-system codes,
// mode codes, controller states and result-status bit positions.
package cordic_pkg;

  localparam logic [1:0] SYS_HYP  = 2'b00;
  localparam logic [1:0] SYS_CIRC = 2'b01;
  localparam logic [1:0] SYS_LIN  = 2'b10;
  localparam logic [1:0] SYS_RSVD = 2'b11;

  localparam logic MODE_ROT = 1'b1;
  localparam logic MODE_VEC = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_ITER,
    ST_DONE
  } state_e;

  // resStatus = {aborted, zOv, yOv, xOv, ovErr, inpErr}
  localparam int unsigned STS_INP_ERR = 0;
  localparam int unsigned STS_OV_ERR  = 1;
  localparam int unsigned STS_X_OV    = 2;
  localparam int unsigned STS_Y_OV    = 3;
  localparam int unsigned STS_Z_OV    = 4;
  localparam int unsigned STS_ABORTED = 5;
  localparam int unsigned STS_W       = 6;

  // True for hyperbolic shift indices that must run twice: 4, 13, 40, ...
  // (k_{n+1} = 3k_n + 1). Only the first 19 terms fit in 32 bits.
  function automatic logic is_hyp_repeat(input logic [31:0] idx);
    logic [31:0] k;
    logic        hit;
    k   = 32'd4;
    hit = 1'b0;
    for (int unsigned n = 0; n < 19; n++) begin
      if (k == idx) hit = 1'b1;
      k = (k * 32'd3) + 32'd1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One combinational CORDIC micro-rotation: arithmetic shifts, add/sub of
// x, y and z, and the two's-complement overflow flag of each adder.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ITER_W = 5
) (
  input  logic [WIDTH-1:0]  x_i,
  input  logic [WIDTH-1:0]  y_i,
  input  logic [WIDTH-1:0]  z_i,
  input  logic [WIDTH-1:0]  angle_i,
  input  logic [ITER_W-1:0] shift_i,
  input  logic [1:0]        sys_i,
  input  logic              mode_i,
  output logic [WIDTH-1:0]  x_o,
  output logic [WIDTH-1:0]  y_o,
  output logic [WIDTH-1:0]  z_o,
  output logic              x_ov_o,
  output logic              y_ov_o,
  output logic              z_ov_o
);

  logic             d_pos;
  logic [WIDTH-1:0] x_sh;
  logic [WIDTH-1:0] y_sh;

  // Returns {overflow, a +/- b}; overflow when the operand signs make the
  // result sign impossible.
  function automatic logic [WIDTH:0] add_sub(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic             sub);
    logic [WIDTH-1:0] r;
    logic             ov;
    r  = sub ? (a - b) : (a + b);
    ov = (a[WIDTH-1] != r[WIDTH-1]) && ((a[WIDTH-1] ^ b[WIDTH-1]) == sub);
    return {ov, r};
  endfunction

  assign x_sh = $signed(x_i) >>> shift_i;
  assign y_sh = $signed(y_i) >>> shift_i;

  // Direction decision and the three adders; x is untouched in linear mode.
  always_comb begin
    d_pos          = (mode_i == MODE_ROT) ? ~z_i[WIDTH-1] : y_i[WIDTH-1];
    {y_ov_o, y_o}  = add_sub(y_i, x_sh, ~d_pos);
    {z_ov_o, z_o}  = add_sub(z_i, angle_i, d_pos);
    x_o            = x_i;
    x_ov_o         = 1'b0;
    if (sys_i == SYS_CIRC) begin
      {x_ov_o, x_o} = add_sub(x_i, y_sh, d_pos);
    end else if (sys_i == SYS_HYP) begin
      {x_ov_o, x_o} = add_sub(x_i, y_sh, ~d_pos);
    end
  end

endmodule

// File: rtl/cordic_iter_engine.sv
// Single-job iterative CORDIC engine with valid/ready job and result
// handshakes, external angle LUT and user tag pass-through.
// Optional macro CORDIC_HYP_REPEAT_EN: repeat hyperbolic shift indices
// 4, 13, 40, ... once each for convergence.
module cordic_iter_engine
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ITER_W = 5,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inValid,
  output logic              inReady,
  input  logic [WIDTH-1:0]  inX,
  input  logic [WIDTH-1:0]  inY,
  input  logic [WIDTH-1:0]  inZ,
  input  logic              inMode,
  input  logic [1:0]        inSys,
  input  logic [ITER_W-1:0] inIter,
  input  logic              inOvStopEn,
  input  logic [TAG_W-1:0]  inTag,
  input  logic              abort,
  output logic              resValid,
  input  logic              resReady,
  output logic [WIDTH-1:0]  resX,
  output logic [WIDTH-1:0]  resY,
  output logic [WIDTH-1:0]  resZ,
  output logic [TAG_W-1:0]  resTag,
  output logic [5:0]        resStatus,
  output logic [ITER_W-1:0] resIterDone,
  output logic [ITER_W-1:0] resOvIter,
  output logic [ITER_W-1:0] lutOffset,
  output logic [1:0]        lutSystem,
  input  logic [WIDTH-1:0]  lutAngle,
  output logic              busy
);

`ifdef CORDIC_HYP_REPEAT_EN
  localparam logic HYP_REPEAT = 1'b1;
`else
  localparam logic HYP_REPEAT = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    x_q, x_d, y_q, y_d, z_q, z_d;
  logic                mode_q, mode_d;
  logic [1:0]          sys_q, sys_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [ITER_W-1:0]   elapsed_q, elapsed_d;
  logic [ITER_W-1:0]   shift_q, shift_d;
  logic [ITER_W-1:0]   ov_iter_q, ov_iter_d;
  logic                ovstop_q, ovstop_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [STS_W-1:0]    status_q, status_d;
  logic                rep_q, rep_d;
  logic                res_valid_q, res_valid_d;

  logic [WIDTH-1:0]    st_x, st_y, st_z;
  logic                st_xov, st_yov, st_zov;
  logic                ov_now;
  logic                inp_err;
  logic                x_nonpos;
  logic [WIDTH:0]      abs_y;

  cordic_stage #(
    .WIDTH  (WIDTH),
    .ITER_W (ITER_W)
  ) u_stage (
    .x_i     (x_q),
    .y_i     (y_q),
    .z_i     (z_q),
    .angle_i (lutAngle),
    .shift_i (shift_q),
    .sys_i   (sys_q),
    .mode_i  (mode_q),
    .x_o     (st_x),
    .y_o     (st_y),
    .z_o     (st_z),
    .x_ov_o  (st_xov),
    .y_ov_o  (st_yov),
    .z_ov_o  (st_zov)
  );

  // One extra bit so |y| of the most negative value is representable.
  assign abs_y    = y_q[WIDTH-1] ? ({1'b0, ~y_q} + 1'b1) : {1'b0, y_q};
  assign x_nonpos = x_q[WIDTH-1] | (x_q == '0);
  assign ov_now   = st_xov | st_yov | st_zov;

  // Controller: job capture, pre-step, iteration commit and result hold.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    mode_d      = mode_q;
    sys_d       = sys_q;
    iter_d      = iter_q;
    elapsed_d   = elapsed_q;
    shift_d     = shift_q;
    ov_iter_d   = ov_iter_q;
    ovstop_d    = ovstop_q;
    tag_d       = tag_q;
    status_d    = status_q;
    rep_d       = rep_q;
    res_valid_d = res_valid_q;
    inp_err     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (inValid) begin
          x_d       = inX;
          y_d       = inY;
          z_d       = inZ;
          mode_d    = inMode;
          sys_d     = inSys;
          iter_d    = inIter;
          ovstop_d  = inOvStopEn;
          tag_d     = inTag;
          status_d  = '0;
          elapsed_d = '0;
          ov_iter_d = '0;
          rep_d     = 1'b0;
          state_d   = ST_PRE;
        end
      end

      ST_PRE: begin
        unique case (sys_q)
          SYS_CIRC: begin
            // Fold operands outside +/-90 deg by a 180 deg rotation.
            if (((mode_q == MODE_ROT) && (z_q[WIDTH-1] ^ z_q[WIDTH-2])) ||
                ((mode_q == MODE_VEC) && x_q[WIDTH-1])) begin
              x_d = '0 - x_q;
              y_d = '0 - y_q;
              z_d = {~z_q[WIDTH-1], z_q[WIDTH-2:0]};
            end
          end
          SYS_HYP: begin
            if ((mode_q == MODE_VEC) && (x_nonpos || (abs_y >= {1'b0, x_q})))
              inp_err = 1'b1;
          end
          SYS_LIN: begin
            if ((mode_q == MODE_VEC) && (x_q == '0))
              inp_err = 1'b1;
          end
          default: inp_err = 1'b1;
        endcase
        shift_d               = (sys_q == SYS_HYP) ? ITER_W'(1) : '0;
        elapsed_d             = '0;
        rep_d                 = 1'b0;
        status_d[STS_INP_ERR] = inp_err;
        state_d               = (inp_err || (iter_q == '0)) ? ST_DONE : ST_ITER;
      end

      ST_ITER: begin
        if (abort) begin
          status_d[STS_ABORTED] = 1'b1;
          state_d               = ST_DONE;
        end else begin
          x_d                  = st_x;
          y_d                  = st_y;
          z_d                  = st_z;
          status_d[STS_X_OV]   = status_q[STS_X_OV] | st_xov;
          status_d[STS_Y_OV]   = status_q[STS_Y_OV] | st_yov;
          status_d[STS_Z_OV]   = status_q[STS_Z_OV] | st_zov;
          status_d[STS_OV_ERR] = status_d[STS_X_OV] | status_d[STS_Y_OV] |
                                 status_d[STS_Z_OV];
          if (ov_now && !status_q[STS_OV_ERR]) ov_iter_d = shift_q;
          elapsed_d = elapsed_q + 1'b1;
          // A repeated index holds the shift (and LUT offset) for one more cycle.
          if (HYP_REPEAT && (sys_q == SYS_HYP) && !rep_q &&
              is_hyp_repeat(32'(shift_q))) begin
            rep_d = 1'b1;
          end else begin
            rep_d = 1'b0;
            if (shift_q != '1) shift_d = shift_q + 1'b1;
          end
          if ((elapsed_d == iter_q) || (ovstop_q && ov_now)) state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        res_valid_d = 1'b1;
        if (res_valid_q && resReady) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      mode_q      <= 1'b0;
      sys_q       <= SYS_CIRC;
      iter_q      <= '0;
      elapsed_q   <= '0;
      shift_q     <= '0;
      ov_iter_q   <= '0;
      ovstop_q    <= 1'b0;
      tag_q       <= '0;
      status_q    <= '0;
      rep_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      mode_q      <= mode_d;
      sys_q       <= sys_d;
      iter_q      <= iter_d;
      elapsed_q   <= elapsed_d;
      shift_q     <= shift_d;
      ov_iter_q   <= ov_iter_d;
      ovstop_q    <= ovstop_d;
      tag_q       <= tag_d;
      status_q    <= status_d;
      rep_q       <= rep_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign inReady     = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign resValid    = res_valid_q;
  assign resX        = x_q;
  assign resY        = y_q;
  assign resZ        = z_q;
  assign resTag      = tag_q;
  assign resStatus   = status_q;
  assign resIterDone = elapsed_q;
  assign resOvIter   = ov_iter_q;
  assign lutOffset   = shift_q;
  assign lutSystem   = sys_q;

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Self-checking bench for cordic_iter_engine: directed cases plus random
// jobs checked against a plain-arithmetic reference model.
module tb_cordic_iter_engine;

`ifdef CORDIC_HYP_REPEAT_EN
  localparam bit HYP_REP = 1'b1;
`else
  localparam bit HYP_REP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [31:0] inX = '0, inY = '0, inZ = '0;
  logic        inMode = 1'b0;
  logic [1:0]  inSys = 2'b01;
  logic [4:0]  inIter = '0;
  logic        inOvStopEn = 1'b0;
  logic [3:0]  inTag = '0;
  logic        abort = 1'b0;
  logic        resValid;
  logic        resReady = 1'b0;
  logic [31:0] resX, resY, resZ;
  logic [3:0]  resTag;
  logic [5:0]  resStatus;
  logic [4:0]  resIterDone, resOvIter, lutOffset;
  logic [1:0]  lutSystem;
  logic [31:0] lutAngle;
  logic        busy;

  logic [31:0] lut_mem [4][32];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign lutAngle = lut_mem[lutSystem][lutOffset];

  cordic_iter_engine #(.WIDTH(32), .ITER_W(5), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
    .inX(inX), .inY(inY), .inZ(inZ), .inMode(inMode), .inSys(inSys),
    .inIter(inIter), .inOvStopEn(inOvStopEn), .inTag(inTag), .abort(abort),
    .resValid(resValid), .resReady(resReady), .resX(resX), .resY(resY),
    .resZ(resZ), .resTag(resTag), .resStatus(resStatus),
    .resIterDone(resIterDone), .resOvIter(resOvIter), .lutOffset(lutOffset),
    .lutSystem(lutSystem), .lutAngle(lutAngle), .busy(busy)
  );

  task automatic check(input string tag, input longint got, input longint exp,
                       input longint tol = 0);
    longint diff;
    total++;
    diff = got - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h tol=%0d", tag, got, exp, tol);
    end
  endtask

  function automatic longint wrap32(input longint v);
    logic [31:0] t;
    t = v[31:0];
    return longint'($signed(t));
  endfunction

  function automatic bit is_rep(input int idx);
    int k;
    k = 4;
    while (k < 32) begin
      if (k == idx) return 1'b1;
      k = 3 * k + 1;
    end
    return 1'b0;
  endfunction

  // Reference: exact integer CORDIC with range-based overflow detection.
  task automatic ref_model(input logic [31:0] x0, y0, z0, input logic mode,
                           input logic [1:0] sys, input int iter, input logic ovs,
                           input int abort_after,
                           output logic [31:0] ex, ey, ez, output logic [5:0] est,
                           output int edone, output int eov);
    longint x, y, z, nx, ny, nz, ang, zu, ay;
    int d, m, idx, n;
    bit xo, yo, zo, inp, ab, fx, fy, fz, did_rep;
    x = longint'($signed(x0));
    y = longint'($signed(y0));
    z = longint'($signed(z0));
    zu = longint'(z0);
    xo = 0; yo = 0; zo = 0; inp = 0; ab = 0; did_rep = 0; n = 0; eov = 0;
    if (sys == 2'b01 && ((mode && zu >= 64'h4000_0000 && zu < 64'hC000_0000) ||
                         (!mode && x < 0))) begin
      x = wrap32(-x);
      y = wrap32(-y);
      z = wrap32(z + 64'h8000_0000);
    end
    ay = (y < 0) ? -y : y;
    if (sys == 2'b11) inp = 1;
    if (sys == 2'b00 && !mode && (x <= 0 || ay >= x)) inp = 1;
    if (sys == 2'b10 && !mode && x == 0) inp = 1;
    m   = (sys == 2'b01) ? 1 : ((sys == 2'b00) ? -1 : 0);
    idx = (sys == 2'b00) ? 1 : 0;
    if (!inp) begin
      while (n < iter) begin
        if (n == abort_after) begin
          ab = 1;
          break;
        end
        ang = longint'($signed(lut_mem[sys][idx]));
        if (mode) d = (z >= 0) ? 1 : -1;
        else      d = (y < 0) ? 1 : -1;
        nx = x - longint'(m * d) * (x == x ? (y >>> idx) : 0);
        ny = y + longint'(d) * (x >>> idx);
        nz = z - longint'(d) * ang;
        fx = (nx != wrap32(nx));
        fy = (ny != wrap32(ny));
        fz = (nz != wrap32(nz));
        if ((fx | fy | fz) && !(xo | yo | zo)) eov = idx;
        xo |= fx; yo |= fy; zo |= fz;
        x = wrap32(nx); y = wrap32(ny); z = wrap32(nz);
        n++;
        if (HYP_REP && sys == 2'b00 && !did_rep && is_rep(idx)) did_rep = 1;
        else begin
          did_rep = 0;
          if (idx < 31) idx++;
        end
        if (ovs && (fx | fy | fz)) break;
      end
    end
    ex = x[31:0]; ey = y[31:0]; ez = z[31:0];
    est = {ab, zo, yo, xo, xo | yo | zo, inp};
    edone = n;
  endtask

  // Runs one job to completion and checks every result field against the model.
  task automatic do_job(input string nm, input logic [31:0] x, y, z,
                        input logic mode, input logic [1:0] sys, input int iter,
                        input logic ovs, input logic [3:0] tag, input int rdy_delay,
                        output logic [31:0] gx, gy, gz, output logic [5:0] gst,
                        output int glat);
    logic [31:0] ex, ey, ez;
    logic [5:0]  est;
    int edone, eov, n;
    ref_model(x, y, z, mode, sys, iter, ovs, -1, ex, ey, ez, est, edone, eov);
    n = 0;
    while (!inReady && n < 10) begin @(posedge clk); #1; n++; end
    check({nm, "_inready"}, inReady, 1);
    inX = x; inY = y; inZ = z; inMode = mode; inSys = sys;
    inIter = 5'(iter); inOvStopEn = ovs; inTag = tag; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    check({nm, "_busy"}, busy, 1);
    glat = 0;
    while (!resValid && glat < 100) begin @(posedge clk); #1; glat++; end
    check({nm, "_latency"}, glat, edone + 2);
    repeat (rdy_delay) begin @(posedge clk); #1; end
    gx = resX; gy = resY; gz = resZ; gst = resStatus;
    check({nm, "_valid"}, resValid, 1);
    check({nm, "_x"}, resX, ex);
    check({nm, "_y"}, resY, ey);
    check({nm, "_z"}, resZ, ez);
    check({nm, "_status"}, resStatus, est);
    check({nm, "_iterdone"}, resIterDone, edone);
    check({nm, "_oviter"}, resOvIter, eov);
    check({nm, "_tag"}, resTag, tag);
    resReady = 1'b1;
    @(posedge clk); #1;
    resReady = 1'b0;
    check({nm, "_valid_drop"}, resValid, 0);
    check({nm, "_inready_back"}, inReady, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] gx, gy, gz, ex, ey, ez, rx, ry, rz;
    logic [5:0]  gst, est;
    logic [1:0]  rs;
    logic        rm;
    int glat, edone, eov, cnt, it;
    real t, kgain;

    for (int i = 0; i < 32; i++) begin
      t = 2.0 ** (-i);
      lut_mem[1][i] = 32'($rtoi($atan(t) / (2.0 * 3.14159265358979) * 4294967296.0 + 0.5));
      if (i == 0) lut_mem[0][i] = '0;
      else lut_mem[0][i] = 32'($rtoi(0.5 * $ln((1.0 + t) / (1.0 - t)) /
                                     (2.0 * 3.14159265358979) * 4294967296.0 + 0.5));
      lut_mem[2][i] = 32'h4000_0000 >> i;
      lut_mem[3][i] = '0;
    end
    kgain = 1.0;
    for (int i = 0; i < 31; i++) kgain = kgain * $sqrt(1.0 + 2.0 ** (-2 * i));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_inready", inReady, 1);
    check("rst_resvalid", resValid, 0);
    check("rst_busy", busy, 0);
    check("rst_resx", resX, 0);
    check("rst_status", resStatus, 0);
    check("rst_lutoff", lutOffset, 0);
    check("rst_lutsys", lutSystem, 2'b01);
    check("rst_tag", resTag, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Circular rotation by 45 deg from the gain-compensated unit vector
    do_job("circ_rot", 32'h26DD3B6A, 32'h0, 32'h2000_0000, 1'b1, 2'b01, 31, 1'b0,
           4'h5, 0, gx, gy, gz, gst, glat);
    check("circ_rot_x_near", longint'($signed(gx)), 64'h2D413CCC, 16);
    check("circ_rot_y_near", longint'($signed(gy)), 64'h2D413CCC, 16);
    check("circ_rot_lat33", glat, 33);
    check("circ_rot_status0", gst, 0);

    // Circular vectoring of (0.5, 0.5)
    do_job("circ_vec", 32'h2000_0000, 32'h2000_0000, 32'h0, 1'b0, 2'b01, 31, 1'b0,
           4'hA, 2, gx, gy, gz, gst, glat);
    check("circ_vec_z_near", longint'($signed(gz)), 64'h2000_0000, 16);
    check("circ_vec_x_near", longint'($signed(gx)),
          longint'($rtoi($sqrt(2.0) * 536870912.0 * kgain + 0.5)), 16);
    check("circ_vec_y_near", longint'($signed(gy)), 0, 16);

    // Hyperbolic vectoring outside the convergence domain
    do_job("hyp_inperr", 32'h1000_0000, 32'h2000_0000, 32'h1234_5678, 1'b0, 2'b00,
           31, 1'b0, 4'h3, 1, gx, gy, gz, gst, glat);
    check("hyp_inperr_status", gst, 6'b000001);
    check("hyp_inperr_x", gx, 32'h1000_0000);
    check("hyp_inperr_z", gz, 32'h1234_5678);
    check("hyp_inperr_lat", glat, 2);

    // Overflow stop on the first iteration
    do_job("ovstop", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h2000_0000, 1'b1, 2'b01, 31,
           1'b1, 4'h7, 0, gx, gy, gz, gst, glat);
    check("ovstop_status", gst, 6'b001010);
    check("ovstop_iterdone", resIterDone, 1);
    check("ovstop_oviter", resOvIter, 0);

    // Zero-iteration job and the reserved system
    do_job("iter0", 32'h1111_0000, 32'h0222_0000, 32'h0333_0000, 1'b1, 2'b10, 0,
           1'b0, 4'h1, 0, gx, gy, gz, gst, glat);
    do_job("rsvd", 32'h1000_0000, 32'h0, 32'h0, 1'b1, 2'b11, 9, 1'b0, 4'h2, 0,
           gx, gy, gz, gst, glat);
    check("rsvd_status", gst, 6'b000001);

    // Abort while elapsed == 5, then a long result stall with abort still high
    rx = 32'h1800_0000; ry = 32'h0400_0000; rz = 32'h1000_0000;
    ref_model(rx, ry, rz, 1'b1, 2'b01, 20, 1'b0, 5, ex, ey, ez, est, edone, eov);
    inX = rx; inY = ry; inZ = rz; inMode = 1'b1; inSys = 2'b01; inIter = 5'd20;
    inOvStopEn = 1'b0; inTag = 4'hC; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    check("abort_pre_elapsed", resIterDone, 5);
    abort = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      check("abort_hold_valid", resValid, 1);
      check("abort_hold_inready", inReady, 0);
      check("abort_hold_x", resX, ex);
      check("abort_hold_status", resStatus, est);
      check("abort_hold_iterdone", resIterDone, 5);
      @(posedge clk); #1;
    end
    check("abort_status_const", est, 6'b100000);
    abort = 1'b0;
    resReady = 1'b1;
    @(posedge clk); #1;
    resReady = 1'b0;
    do_job("after_abort", 32'h0800_0000, 32'h0100_0000, 32'hF000_0000, 1'b1, 2'b01,
           12, 1'b0, 4'h9, 0, gx, gy, gz, gst, glat);

    // Reset pulsed mid-iteration
    inX = 32'h1000_0000; inY = '0; inZ = 32'h0800_0000; inMode = 1'b1;
    inSys = 2'b01; inIter = 5'd31; inTag = 4'hE; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst_resvalid", resValid, 0);
    check("midrst_busy", busy, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_inready", inReady, 1);
    check("midrst_status", resStatus, 0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (resValid) cnt++;
      @(posedge clk); #1;
    end
    check("midrst_no_stale", cnt, 0);

    // Randomised jobs across all systems and modes
    for (int j = 0; j < 40; j++) begin
      rs = 2'($urandom_range(0, 3));
      rm = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        rx = $urandom; ry = $urandom;
      end else begin
        rx = 32'($signed($urandom) >>> 3);
        ry = 32'($signed($urandom) >>> 3);
      end
      if (rs == 2'b00 && !rm && $urandom_range(0, 1) == 1) begin
        rx = 32'h1000_0000 + ($urandom & 32'h0FFF_FFFF);
        ry = $urandom & 32'h07FF_FFFF;
        if ($urandom_range(0, 1) == 1) ry = '0 - ry;
      end
      rz = $urandom;
      it = $urandom_range(0, 31);
      do_job("rand", rx, ry, rz, rm, rs, it, 1'($urandom_range(0, 1)),
             4'($urandom), $urandom_range(0, 3), gx, gy, gz, gst, glat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
